// File: rtl/serial_pattern_detector.sv
// serial_pattern_detector
//   Shifts a qualified serial bit stream (MSB of the pattern first) into a PAT_W-bit window
//   and compares it against a runtime-loadable pattern. A registered one-cycle pulse marks
//   each match, and a saturating counter totals matches since reset or the last cfg_load.
//   Overlapping or non-overlapping detection is selected at cfg_load time.
//
//   Optional feature: define SPD_MASK_EN to add a per-bit don't-care mask (pattern_mask).
//
// Parameters
//   PAT_W        pattern/window width, 2..32
//   CNT_W        match_count width, 1..16
// Ports
//   clk          clock, rising edge
//   reset        asynchronous active-high reset
//   enable       1 = accept bits, 0 = freeze (window and fill count held)
//   data_valid   qualifies data_in
//   data_in      serial bit
//   cfg_load     latch pattern/overlap (and pattern_mask), restart detection
//   pattern      pattern to match, sampled on cfg_load
//   overlap      1 = overlapping matches, sampled on cfg_load
//   pattern_mask don't-care bits, sampled on cfg_load (SPD_MASK_EN only)
//   data_out     one-cycle match pulse
//   match_count  saturating match count
//   cfg_ack      one-cycle pulse the cycle after cfg_load

module serial_pattern_detector #(
    parameter int unsigned PAT_W = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             data_valid,
    input  logic             data_in,
    input  logic             cfg_load,
    input  logic [PAT_W-1:0] pattern,
    input  logic             overlap,
`ifdef SPD_MASK_EN
    input  logic [PAT_W-1:0] pattern_mask,
`endif
    output logic             data_out,
    output logic [CNT_W-1:0] match_count,
    output logic             cfg_ack
);

    localparam int unsigned FW = $clog2(PAT_W + 1);
    localparam logic [FW-1:0] FULL = FW'(PAT_W);

    typedef enum logic [1:0] {StIdle, StFill, StScan} state_e;

    state_e             state_q, state_d;
    logic [PAT_W-1:0]   window_q, window_d;
    logic [FW-1:0]      fill_q, fill_d;
    logic [PAT_W-1:0]   pat_q, pat_d;
    logic               overlap_q, overlap_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               out_q, out_d;
    logic               ack_q, ack_d;
`ifdef SPD_MASK_EN
    logic [PAT_W-1:0]   mask_q, mask_d;
`endif

    logic               acc;
    logic [PAT_W-1:0]   nw;
    logic [FW-1:0]      fill_inc;
    logic               pat_eq;
    logic               hit;

    always_comb begin
        acc      = enable & data_valid & ~cfg_load & (state_q != StIdle);
        nw       = {window_q[PAT_W-2:0], data_in};
        fill_inc = (fill_q == FULL) ? fill_q : fill_q + 1'b1;
`ifdef SPD_MASK_EN
        pat_eq   = ((nw ^ pat_q) & ~mask_q) == '0;
`else
        pat_eq   = (nw == pat_q);
`endif
        // A match needs a full window after this bit's shift.
        hit      = acc & pat_eq & (fill_inc == FULL);
    end

    always_comb begin
        state_d   = state_q;
        window_d  = window_q;
        fill_d    = fill_q;
        pat_d     = pat_q;
        overlap_d = overlap_q;
        count_d   = count_q;
        out_d     = 1'b0;
        ack_d     = 1'b0;
`ifdef SPD_MASK_EN
        mask_d    = mask_q;
`endif

        if (cfg_load) begin
            pat_d     = pattern;
            overlap_d = overlap;
`ifdef SPD_MASK_EN
            mask_d    = pattern_mask;
`endif
            window_d  = '0;
            fill_d    = '0;
            count_d   = '0;
            ack_d     = 1'b1;
            state_d   = enable ? StFill : StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (enable) begin
                        state_d = (fill_q == FULL) ? StScan : StFill;
                    end
                end
                StFill, StScan: begin
                    if (!enable) begin
                        state_d = StIdle;
                    end else if (acc) begin
                        window_d = nw;
                        fill_d   = fill_inc;
                        if (fill_inc == FULL) begin
                            state_d = StScan;
                        end
                        if (hit) begin
                            out_d = 1'b1;
                            if (count_q != '1) begin
                                count_d = count_q + 1'b1;
                            end
                            // Non-overlapping: demand PAT_W fresh bits before the next match.
                            if (!overlap_q) begin
                                fill_d  = '0;
                                state_d = StFill;
                            end
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            window_q  <= '0;
            fill_q    <= '0;
            pat_q     <= '0;
            overlap_q <= 1'b1;
            count_q   <= '0;
            out_q     <= 1'b0;
            ack_q     <= 1'b0;
`ifdef SPD_MASK_EN
            mask_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            window_q  <= window_d;
            fill_q    <= fill_d;
            pat_q     <= pat_d;
            overlap_q <= overlap_d;
            count_q   <= count_d;
            out_q     <= out_d;
            ack_q     <= ack_d;
`ifdef SPD_MASK_EN
            mask_q    <= mask_d;
`endif
        end
    end

    assign data_out    = out_q;
    assign match_count = count_q;
    assign cfg_ack     = ack_q;

endmodule

// File: tb/tb_serial_pattern_detector.sv
// Bench for serial_pattern_detector: directed scenarios followed by random traffic, all
// checked against a queue-based reference model of the bit stream.
module tb_serial_pattern_detector;

    localparam int unsigned PAT_W = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             enable = 1'b0;
    logic             data_valid = 1'b0;
    logic             data_in = 1'b0;
    logic             cfg_load = 1'b0;
    logic [PAT_W-1:0] pattern = '0;
    logic             overlap = 1'b1;
    logic [PAT_W-1:0] mask = '0;

    logic             data_out, cfg_ack, data_out2, cfg_ack2;
    logic [7:0]       match_count;
    logic [1:0]       match_count2;

    always #5 clk = ~clk;

    serial_pattern_detector #(.PAT_W(PAT_W), .CNT_W(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .data_valid  (data_valid),
        .data_in     (data_in),
        .cfg_load    (cfg_load),
        .pattern     (pattern),
        .overlap     (overlap),
`ifdef SPD_MASK_EN
        .pattern_mask(mask),
`endif
        .data_out    (data_out),
        .match_count (match_count),
        .cfg_ack     (cfg_ack)
    );

    // Narrow counter copy, used for the saturation boundary.
    serial_pattern_detector #(.PAT_W(PAT_W), .CNT_W(2)) dut2 (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .data_valid  (data_valid),
        .data_in     (data_in),
        .cfg_load    (cfg_load),
        .pattern     (pattern),
        .overlap     (overlap),
`ifdef SPD_MASK_EN
        .pattern_mask(mask),
`endif
        .data_out    (data_out2),
        .match_count (match_count2),
        .cfg_ack     (cfg_ack2)
    );

    int n_pass = 0;
    int n_total = 0;

    // Reference model: the accepted bits since the last restart, newest at the back.
    bit               hist[$];
    logic [PAT_W-1:0] m_pat, m_mask;
    bit               m_ovl, m_run;
    int               m_cnt, m_cnt2;
    bit               e_out, e_ack;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        hist.delete();
        m_pat = '0; m_mask = '0; m_ovl = 1'b1; m_run = 1'b0;
        m_cnt = 0; m_cnt2 = 0; e_out = 1'b0; e_ack = 1'b0;
    endtask

    function automatic bit window_matches();
        for (int i = 0; i < PAT_W; i++) begin
            // hist[0] is the oldest bit, which lines up with the pattern MSB.
            if (!m_mask[PAT_W-1-i] && hist[i] != m_pat[PAT_W-1-i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_step();
        e_ack = cfg_load;
        e_out = 1'b0;
        if (cfg_load) begin
            m_pat = pattern;
            m_ovl = overlap;
`ifdef SPD_MASK_EN
            m_mask = mask;
`else
            m_mask = '0;
`endif
            hist.delete();
            m_cnt = 0; m_cnt2 = 0;
            m_run = enable;
        end else begin
            // Bits count only once the detector has been running for a cycle.
            if (m_run && enable && data_valid) begin
                hist.push_back(data_in);
                if (hist.size() > PAT_W) void'(hist.pop_front());
                if (hist.size() == PAT_W && window_matches()) begin
                    e_out = 1'b1;
                    if (m_cnt < 255) m_cnt++;
                    if (m_cnt2 < 3) m_cnt2++;
                    if (!m_ovl) hist.delete();
                end
            end
            m_run = enable;
        end
    endtask

    task automatic step(input bit en, input bit dv, input bit d, input bit ld);
        enable = en; data_valid = dv; data_in = d; cfg_load = ld;
        model_step();
        @(posedge clk);
        #1;
        check("data_out", 32'(data_out), 32'(e_out));
        check("match_count", 32'(match_count), 32'(m_cnt));
        check("cfg_ack", 32'(cfg_ack), 32'(e_ack));
        check("data_out_w2", 32'(data_out2), 32'(e_out));
        check("match_count_w2", 32'(match_count2), 32'(m_cnt2));
    endtask

    task automatic load(input logic [PAT_W-1:0] p, input bit ovl, input logic [PAT_W-1:0] m);
        pattern = p; overlap = ovl; mask = m;
        step(1'b1, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic bits(input logic [7:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) step(1'b1, 1'b1, v[i], 1'b0);
    endtask

    task automatic do_reset();
        #2 reset = 1'b1;
        #1;
        check("rst_data_out", 32'(data_out), 32'd0);
        check("rst_match_count", 32'(match_count), 32'd0);
        check("rst_cfg_ack", 32'(cfg_ack), 32'd0);
        model_reset();
        #1 reset = 1'b0;
    endtask

    initial begin
        model_reset();
        @(posedge clk);
        #1;
        do_reset();
        step(1'b0, 1'b0, 1'b0, 1'b0);

        // 1: overlapping 1010
        load(4'b1010, 1'b1, 4'b0000);
        bits(8'b101010, 6);
        check("t1_count", 32'(match_count), 32'd2);

        // 2: non-overlapping, extended stream
        load(4'b1010, 1'b0, 4'b0000);
        bits(8'b10101010, 8);
        check("t2_count", 32'(match_count), 32'd2);

        // 3: gaps and a 3-cycle freeze after bit 2
        load(4'b1010, 1'b1, 4'b0000);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        repeat (3) step(1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        check("t3_count", 32'(match_count), 32'd1);

        // 4: cfg_load coinciding with a valid bit drops that bit
        bits(8'b11, 2);
        pattern = 4'b1100;
        step(1'b1, 1'b1, 1'b1, 1'b1);
        check("t4_count", 32'(match_count), 32'd0);
        bits(8'b1100, 4);
        check("t4_count_end", 32'(match_count), 32'd1);

        // 5: saturation of the 2-bit counter
        load(4'b1111, 1'b1, 4'b0000);
        bits(8'b1111111, 7);
        check("t5_count_w2", 32'(match_count2), 32'd3);
        check("t5_count", 32'(match_count), 32'd4);

        // 6: async reset mid-SCAN
        do_reset();
        step(1'b1, 1'b1, 1'b1, 1'b0);
`ifdef SPD_MASK_EN
        load(4'b1010, 1'b0, 4'b0001);
        bits(8'b1011, 4);
        bits(8'b1010, 4);
        check("t6_mask_count", 32'(match_count), 32'd2);
`endif

        // Random traffic with occasional reconfiguration
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                pattern = PAT_W'($urandom);
                overlap = 1'($urandom);
                mask = ($urandom_range(0, 1) == 0) ? '0 : PAT_W'($urandom);
                step(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom), 1'b1);
            end else begin
                step(1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 3) != 0),
                     1'($urandom), 1'b0);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
